// File: rtl/com_csr_pkg.sv
// Shared definitions for the CSR-to-APB bridge slice.
//   csr2apb_state_e : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   PPROT_DEFAULT   : protection attribute driven on every APB transfer
package com_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } csr2apb_state_e;

  // Normal, secure, data access.
  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/com_csr_wdog.sv
// Watchdog counter for stalled APB ACCESS phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart of the count
//   enable     : count this cycle (completer is stalling)
//   expire     : high in the enabled cycle that is the LIMIT-th stalled one
module com_csr_wdog
  import com_csr_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // Counter only needs to reach LIMIT-1; expiry is flagged combinationally
  // in the LIMIT-th enabled cycle so the owner can react on that same edge.
  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt_q;

  assign expire = enable && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || expire) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/com_csr_csr2apb.sv
// CSR request/response to APB4 requester bridge.
// One transfer at a time: a request is captured in IDLE, driven as an APB
// SETUP + ACCESS sequence, and reported on the response channel in RESP.
// Ports:
//   clk, rst_n, clear            : clock, async active-low reset, sync clear
//   req_valid/req_ready/...      : CSR request channel (write, addr, wdata, wstrb)
//   rsp_valid/rsp_ready/...      : CSR response channel (rdata, err)
//   PADDR..PSTRB                 : APB4 requester outputs
//   PREADY, PRDATA, PSLVERR      : APB4 completer inputs
module com_csr_csr2apb
  import com_csr_pkg::*;
#(
  parameter int unsigned          AW_CSR    = 20,
  parameter int unsigned          AW_APB    = 32,
  parameter int unsigned          DW        = 32,
  parameter logic [AW_APB-1:0]    BASE_ADDR = '0,
  parameter int unsigned          TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AW_CSR-1:0]   req_addr,
  input  logic [DW-1:0]       req_wdata,
  input  logic [DW/8-1:0]     req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  output logic [AW_APB-1:0]   PADDR,
  output logic [2:0]          PPROT,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DW-1:0]       PWDATA,
  output logic [DW/8-1:0]     PSTRB,
  input  logic                PREADY,
  input  logic [DW-1:0]       PRDATA,
  input  logic                PSLVERR
);

  csr2apb_state_e state_q, state_d;

  logic              accept;
  logic              wdog_en;
  logic              wdog_clr;
  logic              wdog_expire;
  logic [AW_APB-1:0] addr_sum;
  logic [DW-1:0]     rdata_q;
  logic              err_q;

  assign req_ready = (state_q == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  // APB control is decoded straight from the state, so PENABLE can only be
  // high in ACCESS, where PSELx is also high.
  assign PSELx     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PPROT     = PPROT_DEFAULT;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Sum wraps naturally at AW_APB bits; word alignment applied on capture.
  assign addr_sum  = BASE_ADDR + AW_APB'(req_addr);

  assign wdog_en   = (state_q == ST_ACCESS) && !PREADY;
  assign wdog_clr  = (state_q != ST_ACCESS) || clear;

  com_csr_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wdog_clr),
    .enable (wdog_en),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (req_valid)              state_d = ST_SETUP;
        ST_SETUP:                              state_d = ST_ACCESS;
        ST_ACCESS: if (PREADY || wdog_expire)  state_d = ST_RESP;
        ST_RESP:   if (rsp_ready)              state_d = ST_IDLE;
        default:                               state_d = ST_IDLE;
      endcase
    end
  end

  // Request fields are captured only on acceptance and then held untouched,
  // which keeps the APB address/data/strobe stable for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      PADDR  <= {addr_sum[AW_APB-1:2], 2'b00};
      PWRITE <= req_write;
      PWDATA <= req_wdata;
      PSTRB  <= req_write ? req_wstrb : '0;
    end
  end

  // Response data is zero for writes, slave errors and timeouts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (!clear && (state_q == ST_ACCESS)) begin
      if (PREADY) begin
        err_q   <= PSLVERR;
        rdata_q <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
      end else if (wdog_expire) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_com_csr_csr2apb.sv
// Self-checking bench for com_csr_csr2apb: directed vector table, randomized
// transactions against a transaction-level model, and hand sequences for
// reset, clear, timeout and back-to-back issue.
module tb_com_csr_csr2apb;

  localparam int          TIMEOUT = 8;
  localparam logic [31:0] BASE    = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  // completer behaviour for the current transfer
  int          slv_wait  = 0;
  logic        slv_hang  = 1'b0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cycles = 0;

  typedef struct {
    logic        write;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_st;
    logic        hang;
    logic        serr;
    logic [31:0] srdata;
    int          hold;
    logic [31:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  com_csr_csr2apb #(
    .AW_CSR    (20),
    .AW_APB    (32),
    .DW        (32),
    .BASE_ADDR (BASE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PPROT     (PPROT),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: what the bridge should report for a request
  // given how the completer behaves.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_paddr = (BASE + {12'h000, v.addr}) & 32'hFFFF_FFFC;
    r.exp_pstrb = v.write ? v.wstrb : 4'h0;
    if (v.hang) begin
      r.exp_acc   = TIMEOUT;
      r.exp_err   = 1'b1;
      r.exp_rdata = '0;
    end else begin
      r.exp_acc   = v.wait_st + 1;
      r.exp_err   = v.serr;
      r.exp_rdata = (v.write || v.serr) ? 32'h0 : v.srdata;
    end
    return r;
  endfunction

  // APB completer: answers after slv_wait stalled ACCESS cycles, or never.
  always @(negedge clk) begin
    if (PSELx && PENABLE) acc_cycles = acc_cycles + 1;
    else                  acc_cycles = 0;
    PREADY  = PSELx && PENABLE && !slv_hang && (acc_cycles > slv_wait);
    PRDATA  = PREADY ? slv_rdata : $urandom;
    PSLVERR = PREADY && slv_err;
  end

  // APB protocol monitor.
  logic        prev_psel = 1'b0;
  logic [31:0] prev_paddr, prev_pwdata;
  logic [3:0]  prev_pstrb;
  logic        prev_pwrite;

  always @(negedge clk) begin
    if (PSELx || PENABLE) checkOutput("penable_implies_psel", PSELx, 1'b1);
    if (PSELx && prev_psel) begin
      checkOutput("access_follows_setup", PENABLE, 1'b1);
      checkOutput("paddr_stable", PADDR, prev_paddr);
      checkOutput("pwrite_stable", PWRITE, prev_pwrite);
      checkOutput("pwdata_stable", PWDATA, prev_pwdata);
      checkOutput("pstrb_stable", PSTRB, prev_pstrb);
    end else if (PSELx) begin
      checkOutput("setup_penable_low", PENABLE, 1'b0);
    end
    prev_psel   = PSELx;
    prev_paddr  = PADDR;
    prev_pwdata = PWDATA;
    prev_pstrb  = PSTRB;
    prev_pwrite = PWRITE;
  end

  // Present a request from a negedge and return at the negedge of SETUP.
  task automatic start_req(input logic w, input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
    int guard = 0;
    req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("req_ready_for_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int   lat = 1;
    int   acc = 0;
    logic setup_seen = 1'b0;
    slv_wait = v.wait_st; slv_hang = v.hang; slv_err = v.serr; slv_rdata = v.srdata;
    start_req(v.write, v.addr, v.wdata, v.wstrb);
    while (!rsp_valid && lat < 40) begin
      if (PSELx && !PENABLE && !setup_seen) begin
        setup_seen = 1'b1;
        checkOutput("paddr", PADDR, v.exp_paddr);
        checkOutput("pstrb", PSTRB, v.exp_pstrb);
        checkOutput("pwrite", PWRITE, v.write);
        checkOutput("pprot", PPROT, 3'b000);
        if (v.write) checkOutput("pwdata", PWDATA, v.wdata);
      end
      if (PENABLE) acc++;
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_valid_seen", rsp_valid, 1'b1);
    checkOutput("setup_seen", setup_seen, 1'b1);
    checkOutput("access_cycles", acc, v.exp_acc);
    checkOutput("latency", lat, 2 + v.exp_acc);
    checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
    checkOutput("rsp_err", rsp_err, v.exp_err);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", rsp_valid, 1'b1);
      checkOutput("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
      checkOutput("hold_rsp_err", rsp_err, v.exp_err);
      checkOutput("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_released", rsp_valid, 1'b0);
    checkOutput("idle_req_ready", req_ready, 1'b1);
  endtask

  // Wait (bounded) for the ACCESS phase of the current transfer.
  task automatic wait_access();
    int guard = 0;
    while (!PENABLE && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reached_access", PENABLE, 1'b1);
  endtask

  vec_t dir_vecs[5];

  initial begin
    int accepts[$];
    vec_t v;

    dir_vecs[0] = '{write:1'b0, addr:20'h00010, wdata:32'h0, wstrb:4'h0, wait_st:0, hang:1'b0,
                    serr:1'b0, srdata:32'hDEAD_BEEF, hold:0, exp_paddr:32'h4000_0010,
                    exp_pstrb:4'h0, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0, exp_acc:1};
    dir_vecs[1] = '{write:1'b1, addr:20'h00123, wdata:32'h1234_5678, wstrb:4'b0101, wait_st:3,
                    hang:1'b0, serr:1'b0, srdata:32'h7777_7777, hold:1, exp_paddr:32'h4000_0120,
                    exp_pstrb:4'b0101, exp_rdata:32'h0, exp_err:1'b0, exp_acc:4};
    dir_vecs[2] = '{write:1'b0, addr:20'h00400, wdata:32'h0, wstrb:4'h0, wait_st:0, hang:1'b1,
                    serr:1'b0, srdata:32'h1111_1111, hold:0, exp_paddr:32'h4000_0400,
                    exp_pstrb:4'h0, exp_rdata:32'h0, exp_err:1'b1, exp_acc:8};
    dir_vecs[3] = '{write:1'b0, addr:20'h0FFFF, wdata:32'h0, wstrb:4'h0, wait_st:0, hang:1'b0,
                    serr:1'b1, srdata:32'h55AA_55AA, hold:5, exp_paddr:32'h4000_FFFC,
                    exp_pstrb:4'h0, exp_rdata:32'h0, exp_err:1'b1, exp_acc:1};
    dir_vecs[4] = '{write:1'b0, addr:20'hFFFFF, wdata:32'h0, wstrb:4'h0, wait_st:1, hang:1'b0,
                    serr:1'b0, srdata:32'hCAFE_F00D, hold:1, exp_paddr:32'h400F_FFFC,
                    exp_pstrb:4'h0, exp_rdata:32'hCAFE_F00D, exp_err:1'b0, exp_acc:2};

    // reset, with a request pending that must not be captured
    rst_n = 1'b0; clear = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'hABCDE;
    req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("rst_psel", PSELx, 1'b0);
    checkOutput("rst_penable", PENABLE, 1'b0);
    checkOutput("rst_pwrite", PWRITE, 1'b0);
    checkOutput("rst_paddr", PADDR, 32'h0);
    checkOutput("rst_pwdata", PWDATA, 32'h0);
    checkOutput("rst_pstrb", PSTRB, 4'h0);
    checkOutput("rst_pprot", PPROT, 3'h0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", rsp_err, 1'b0);
    checkOutput("rst_req_ready", req_ready, 1'b1);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_paddr", PADDR, 32'h0);
    checkOutput("post_rst_psel", PSELx, 1'b0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 5; i++) applyStimulus(dir_vecs[i]);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 30; i++) begin
      v.write   = 1'($urandom_range(0, 1));
      v.addr    = 20'($urandom);
      v.wdata   = $urandom;
      v.wstrb   = 4'($urandom);
      v.wait_st = $urandom_range(0, 3);
      v.hang    = ($urandom_range(0, 7) == 0);
      v.serr    = ($urandom_range(0, 3) == 0);
      v.srdata  = $urandom;
      v.hold    = $urandom_range(0, 2);
      applyStimulus(model(v));
    end

    $display("[TB] clear during ACCESS");
    slv_hang = 1'b1;
    start_req(1'b0, 20'h00200, 32'h0, 4'h0);
    wait_access();
    clear = 1'b1;
    @(negedge clk);
    checkOutput("clear_psel", PSELx, 1'b0);
    checkOutput("clear_penable", PENABLE, 1'b0);
    checkOutput("clear_rsp_valid", rsp_valid, 1'b0);
    checkOutput("clear_req_ready_low", req_ready, 1'b0);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("after_clear_req_ready", req_ready, 1'b1);
      checkOutput("after_clear_rsp_valid", rsp_valid, 1'b0);
    end

    $display("[TB] reset during ACCESS");
    start_req(1'b1, 20'h00300, 32'hA5A5_A5A5, 4'hF);
    wait_access();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_psel", PSELx, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("after_rst_rsp_valid", rsp_valid, 1'b0);
      checkOutput("after_rst_req_ready", req_ready, 1'b1);
    end

    $display("[TB] back-to-back issue");
    slv_hang = 1'b0; slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0BAD_CAFE;
    rsp_ready = 1'b1;
    req_write = 1'b0; req_addr = 20'h00040; req_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (req_ready) begin
        accepts.push_back(c);
        @(negedge clk);
        req_addr = 20'($urandom);
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("b2b_accept_count", accepts.size(), 6);
    for (int i = 1; i < accepts.size(); i++)
      checkOutput("b2b_interval", accepts[i] - accepts[i-1], 4);
    checkOutput("b2b_idle", req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stopped");
  end

endmodule
